send: RTL
=========

SEND -- requirements
Module: send

Interface
REQ-001 Parameter CLK_BAUD_RATIO, default 2: clock cycles per serial bit; must be >= 1.
REQ-002 Parameter FRAME_SIZE, default 8: data bits per frame.
REQ-003 Parameter FRAMES, default 3: frames per word.
REQ-004 clk_in  input  1  the only clock; all logic on its rising edge.
REQ-005 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-006 data_in  input  FRAME_SIZE*FRAMES  word to transmit.
REQ-007 send_in  input  1  request; a word is accepted on a cycle where send_in and ready_out are both 1.
REQ-008 ready_out  output  1  holding register empty; a word can be accepted this cycle.
REQ-009 tx_out  output  1  serial line, idle high.
REQ-010 busy_out  output  1  a word is being shifted out or one is held.
REQ-011 done_out  output  1  single-cycle pulse when the last stop bit of a word completes.

Function
REQ-012 Line format per frame: one start bit (0), FRAME_SIZE data bits LSB-first, one stop bit (1); no parity.
REQ-013 Frame order: frame 0 = data_in[FRAME_SIZE-1:0] first, then ascending frames; this matches the recv ordering.
REQ-014 Every bit is held on tx_out for exactly CLK_BAUD_RATIO cycles, counted by a baud counter 0..CLK_BAUD_RATIO-1 that reloads at each bit boundary.
REQ-015 FSM states are IDLE, START, DATA, STOP; transitions occur only at bit boundaries.
- IDLE->START when a word is available.
- START->DATA after 1 bit.
- DATA->STOP after FRAME_SIZE bits.
- STOP->START if frames remain or a held word exists; otherwise STOP->IDLE.
REQ-016 Frames of one word are back-to-back with no idle gap; a word occupies exactly FRAMES*(FRAME_SIZE+2)*CLK_BAUD_RATIO cycles.
REQ-017 Latency: a word accepted in IDLE at cycle N drives the start bit on tx_out from cycle N+1.
REQ-018 A one-entry holding register captures data_in on acceptance; ready_out = holding register empty, so a second word can be accepted while the first is shifting.
REQ-019 When a word completes and a word is held, the held word starts at the next cycle with no idle bit, and ready_out rises in that same cycle.
REQ-020 Simultaneous events: acceptance in the same cycle the shifter drains the held word is legal; the new word is held and nothing is lost.
REQ-021 send_in while ready_out=0 is ignored; data_in is not sampled.
REQ-022 data_in changes after acceptance have no effect on the word in flight.
REQ-023 done_out pulses in the final cycle of the last stop bit of each word.
REQ-024 busy_out=0 only in IDLE with the holding register empty.

Reset
REQ-025 While rst_in=0, outputs are forced immediately, without waiting for a clock edge: tx_out=1, ready_out=1, busy_out=0, done_out=0.
REQ-026 While rst_in=0, the FSM is in IDLE, the counters are 0 and the holding register is empty.
REQ-027 Reset mid-frame aborts the word with no partial completion, and no done_out pulse follows.
REQ-028 The first acceptance is possible on the first clock edge after rst_in rises.

Structure
REQ-029 Package comms_pkg holds the FSM state enum and the default CLK_BAUD_RATIO, FRAME_SIZE and FRAMES constants; recv uses the same package.
REQ-030 One sub-module, baud_gen, holds the baud counter and outputs a bit-boundary tick; it reloads on start of transmission and resets asynchronously.
REQ-031 Elaboration fails if CLK_BAUD_RATIO < 1, FRAME_SIZE < 1 or FRAMES < 1.

Verification
REQ-032 Defaults, data_in=24'h4E3B2F, one send_in pulse -> tx_out shows 0,1,1,1,1,0,1,0,0,1, then frames 3B and 4E, each bit 2 cycles.
- Total 60 cycles.
- done_out pulses at cycle 60.
REQ-033 Loopback tx_out -> recv (same parameters) over 3 words -> recv data_out matches each word and new_data_out pulses once per word.
REQ-034 Second word accepted at cycle 5 of the first word -> ready_out is 0 until cycle 60, then words run back-to-back, 120 cycles total with no idle high bit between them.
REQ-035 send_in held high while ready_out=0 with changing data_in -> only the accepted words appear on tx_out.
REQ-036 rst_in low at cycle 17 of a word -> tx_out=1 immediately, no done_out pulse, and a fresh word after release transmits correctly.
REQ-037 CLK_BAUD_RATIO=1, FRAMES=1, data 8'hA5 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1.

Source files
------------

// File: rtl/comms_pkg.sv
// Shared definitions for the serial link: FSM state encoding, default framing
// constants and a small helper for sizing counters.
package comms_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int DEF_CLK_BAUD_RATIO = 2;
    localparam int DEF_FRAME_SIZE     = 8;
    localparam int DEF_FRAMES         = 3;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Baud counter: counts clocks within one serial bit and flags the bit boundary.
module baud_gen
    import comms_pkg::*;
#(
    parameter int CLK_BAUD_RATIO = DEF_CLK_BAUD_RATIO
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en_i,
    input  logic load_i,
    output logic tick_o
);

    localparam int            CW   = cnt_w(CLK_BAUD_RATIO);
    localparam logic [CW-1:0] LAST = CW'(CLK_BAUD_RATIO - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Restart at every bit boundary, on a fresh start, and whenever the line is idle.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (load_i || !en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/send.sv
// Serial transmitter: a word of FRAMES frames, each framed as start bit, LSB-first
// data and stop bit, with a one-entry holding register for back-to-back words.
module send
    import comms_pkg::*;
#(
    parameter int CLK_BAUD_RATIO = DEF_CLK_BAUD_RATIO,
    parameter int FRAME_SIZE     = DEF_FRAME_SIZE,
    parameter int FRAMES         = DEF_FRAMES
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [FRAME_SIZE*FRAMES-1:0] data_in,
    input  logic                         send_in,
    output logic                         ready_out,
    output logic                         tx_out,
    output logic                         busy_out,
    output logic                         done_out
);

    localparam int W  = FRAME_SIZE * FRAMES;
    localparam int BW = cnt_w(FRAME_SIZE);
    localparam int FW = cnt_w(FRAMES);

    if (CLK_BAUD_RATIO < 1) begin : g_bad_ratio
        $error("send: CLK_BAUD_RATIO must be >= 1");
    end
    if (FRAME_SIZE < 1) begin : g_bad_size
        $error("send: FRAME_SIZE must be >= 1");
    end
    if (FRAMES < 1) begin : g_bad_frames
        $error("send: FRAMES must be >= 1");
    end

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            tx_q, tx_d;
    logic            hold_vld_q, hold_vld_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [W-1:0]    hold_q, hold_d;

    logic tick;
    logic accept;
    logic last_bit;
    logic last_frame;
    logic word_end;
    logic bypass;

    assign accept     = send_in && !hold_vld_q;
    assign last_bit   = (bit_q == BW'(FRAME_SIZE - 1));
    assign last_frame = (frame_q == FW'(FRAMES - 1));
    assign word_end   = tick && (state_q == STOP) && last_frame;
    // An accepted word goes straight to the shifter when nothing else is waiting for it.
    assign bypass     = accept && ((state_q == IDLE) || (word_end && !hold_vld_q));

    baud_gen #(
        .CLK_BAUD_RATIO(CLK_BAUD_RATIO)
    ) u_baud (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en_i   (state_q != IDLE),
        .load_i ((state_q == IDLE) && accept),
        .tick_o (tick)
    );

    // Next-state logic for the line FSM, shifter and holding register.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;

        if (word_end && hold_vld_q) begin
            hold_vld_d = 1'b0;
        end
        if (accept && !bypass) begin
            hold_d     = data_in;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = data_in;
                    frame_d = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (last_bit) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (!last_frame) begin
                        frame_d = frame_q + 1'b1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else if (hold_vld_q || accept) begin
                        shift_d = hold_vld_q ? hold_q : data_in;
                        frame_d = '0;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Control registers: FSM state, counters, line level and holding-register flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            frame_q    <= '0;
            tx_q       <= 1'b1;
            hold_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            tx_q       <= tx_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    // Data registers: contents are only meaningful when the matching control says so.
    always_ff @(posedge clk_in) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

    assign ready_out = !hold_vld_q;
    assign tx_out    = tx_q;
    assign busy_out  = (state_q != IDLE) || hold_vld_q;
    assign done_out  = word_end;

endmodule
